booth_mul_scheduler: RTL and testbench
======================================

// Module: booth_mul_scheduler
// PURPOSE
//  Shares one sequential Booth multiplier (start/done handshake, 2*WIDTH-bit product) among
//  N_REQ requesters. Round-robin grant, operand latching, start pulse, completion detect,
//  timeout watchdog, and a tagged response channel. Sits between client engines and the core.
// PARAMETERS
//  WIDTH    32   operand width; product is 2*WIDTH
//  N_REQ    4    number of requesters (>=2)
//  ID_W     2    requester-id width, = clog2(N_REQ)
//  TIMEOUT  128  max cycles in WAIT before the op is aborted with rsp_err
// PORTS
//  clk             in   1             single clock, rising edge
//  rst             in   1             asynchronous, active-high reset
//  req_valid       in   N_REQ         per-requester request pending
//  req_ready       out  N_REQ         one-hot accept pulse; operands taken when valid&ready
//  req_a           in   N_REQ*WIDTH   multiplicands, requester i at [i*WIDTH +: WIDTH]
//  req_b           in   N_REQ*WIDTH   multipliers, same packing
//  rsp_valid       out  1             response held until rsp_ready
//  rsp_ready       in   1             consumer accepts response
//  rsp_id          out  ID_W          requester the response belongs to
//  rsp_product     out  2*WIDTH       signed product (zero when rsp_err)
//  rsp_err         out  1             op timed out
//  mul_start       out  1             one-cycle start pulse to the core
//  mul_multiplicand out WIDTH         held stable from LAUNCH until leaving WAIT
//  mul_multiplier  out  WIDTH         held stable from LAUNCH until leaving WAIT
//  mul_product     in   2*WIDTH       core result, valid when mul_done rises
//  mul_done        in   1             core completion level
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_err=0,
//   mul_start=0, mul operands=0, rr pointer=N_REQ-1 (requester 0 wins first), done_q=0.
//  Reset mid-operation aborts everything; in-flight op lost, no response emitted.
//  FSM: IDLE -> GRANT -> LAUNCH -> WAIT -> RESP -> IDLE.
//   IDLE  : if any req_valid, pick winner = first valid at ptr+1, ptr+2, ... (wraps mod N_REQ);
//           register winner id; -> GRANT.
//   GRANT : req_ready[winner]=1 for exactly this cycle; latch req_a/req_b slices into
//           mul_multiplicand/mul_multiplier; ptr<=winner. If req_valid[winner] dropped,
//           no handshake: -> IDLE, ptr unchanged.
//   LAUNCH: mul_start=1 one cycle; clear timeout counter; -> WAIT.
//   WAIT  : done_q <= mul_done each cycle. Completion = mul_done & ~done_q, ignoring the
//           first WAIT cycle (stale done from a prior op never counts). On completion capture
//           mul_product, rsp_err=0 -> RESP. If counter reaches TIMEOUT first: rsp_product=0,
//           rsp_err=1 -> RESP. Completion and timeout in same cycle: completion wins.
//   RESP  : rsp_valid=1, rsp_id/product/err stable; on rsp_ready -> IDLE, rsp_valid=0 next.
//  Latency: request accepted 2 cycles after valid seen in IDLE; response 1 cycle after
//   done edge. One op outstanding; req_ready low for all others throughout.
//  Fairness: a continuously-valid requester waits at most N_REQ-1 grants.
//  Timeout counter: clog2(TIMEOUT+1) bits, saturating, reset only in LAUNCH.
//  Requests with req_valid while not in IDLE are simply held by the requester (no queue).
// STRUCTURE
//  Package booth_sched_pkg: state encodings (IDLE..RESP, 3-bit), clog2 function,
//   default TIMEOUT constant.
//  Sub-module rr_arbiter #(N_REQ): inputs req vector + ptr, output one-hot grant + id;
//   purely combinational, instantiated once. Everything else in this module.
// TESTING
//  Single req0 a=7,b=-3 with model core -> req_ready[0] 1 cycle, rsp_id=0, product=-21, err=0.
//  All 4 valid continuously, 8 ops -> rsp_id sequence 0,1,2,3,0,1,2,3; no starvation.
//  Core done held high from previous op -> no early completion; next result correct.
//  Core never raises done -> rsp_err=1, rsp_product=0 after exactly TIMEOUT WAIT cycles.
//  rsp_ready low for 10 cycles -> rsp_* stable, no new mul_start, no req_ready.
//  rst asserted during WAIT -> all outputs at reset values asynchronously; no rsp_valid.

Source files
------------

// File: rtl/booth_sched_pkg.sv
// Shared constants for the Booth multiplier scheduler.
// State encodings, default watchdog limit and a width helper.
package booth_sched_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam int DEF_TIMEOUT = 128;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/booth_mul_scheduler_rr_arbiter.sv
// Combinational round-robin pick among the pending requesters.
// Search starts just after ptr and wraps modulo N_REQ.
module rr_arbiter
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
)(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    assign any = |req;

    // First requesting index at ptr+1, ptr+2, ... wins.
    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N_REQ))
                sum = sum - (ID_W+1)'(N_REQ);
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
    end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Shares one sequential Booth multiplier among N_REQ clients.
// Round-robin grant, single op in flight, watchdog, tagged response.
module booth_mul_scheduler
    import booth_sched_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_product,
    output logic                   rsp_err,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_multiplicand,
    output logic [WIDTH-1:0]       mul_multiplier,
    input  logic [2*WIDTH-1:0]     mul_product,
    input  logic                   mul_done
);

    localparam int CNT_W = clog2(TIMEOUT + 1);

    logic [2:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win_id;
    logic [N_REQ-1:0] gnt_q;
    logic [ID_W-1:0]  arb_id;
    logic [N_REQ-1:0] arb_gnt;
    logic             arb_any;
    logic             done_q;
    logic [CNT_W-1:0] cnt;
    logic             done_edge;
    logic             tmo;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .gnt(arb_gnt),
        .id (arb_id),
        .any(arb_any)
    );

    assign req_ready = (state == S_GRANT) ? gnt_q : '0;
    assign mul_start = (state == S_LAUNCH);

    // cnt is zero only in the first WAIT cycle, where a stale done
    // level left over from the previous op must not count.
    assign done_edge = mul_done & ~done_q & (cnt != '0);
    assign tmo       = (cnt == CNT_W'(TIMEOUT - 1));

    // Main control: arbitration, operand capture, wait and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            ptr              <= ID_W'(N_REQ - 1);
            win_id           <= '0;
            gnt_q            <= '0;
            done_q           <= 1'b0;
            cnt              <= '0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            rsp_valid        <= 1'b0;
            rsp_id           <= '0;
            rsp_product      <= '0;
            rsp_err          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        win_id <= arb_id;
                        gnt_q  <= arb_gnt;
                        state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (|(req_valid & gnt_q)) begin
                        mul_multiplicand <=
                            req_a[int'(win_id)*WIDTH +: WIDTH];
                        mul_multiplier   <=
                            req_b[int'(win_id)*WIDTH +: WIDTH];
                        ptr   <= win_id;
                        state <= S_LAUNCH;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    done_q <= mul_done;
                    if (cnt != CNT_W'(TIMEOUT))
                        cnt <= cnt + 1'b1;
                    if (done_edge) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= win_id;
                        rsp_product <= mul_product;
                        rsp_err     <= 1'b0;
                        state       <= S_RESP;
                    end else if (tmo) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= win_id;
                        rsp_product <= '0;
                        rsp_err     <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Randomized bench for booth_mul_scheduler with a behavioural
// multiplier core, round-robin model and response scoreboard.
module tb_booth_mul_scheduler;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TMO = 128;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_product;
    logic             rsp_err;
    logic             mul_start;
    logic [W-1:0]     mul_multiplicand;
    logic [W-1:0]     mul_multiplier;
    logic [2*W-1:0]   mul_product;
    logic             mul_done;

    booth_mul_scheduler #(
        .WIDTH(W), .N_REQ(N), .ID_W(IDW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product),
        .rsp_err(rsp_err), .mul_start(mul_start),
        .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier),
        .mul_product(mul_product), .mul_done(mul_done)
    );

    typedef struct {
        int          id;
        logic [63:0] prod;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cyc = -100;
    int   ops_left [N];
    int   last_id  = N - 1;
    int   lat_min  = 1;
    int   lat_max  = 8;
    bit   keep_done = 0;
    bit   core_hang = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a,
                                         input logic [31:0] b);
        logic signed [63:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    // Round-robin model: next valid requester after the last winner.
    function automatic int predict(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic load(input int i, input int n);
        ops_left[i] = n;
        req_a[i*W +: W] = rnd_op();
        req_b[i*W +: W] = rnd_op();
        req_valid[i] = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget &&
               (exp_q.size() != 0 || req_valid != '0 || rsp_valid)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(k < budget), 64'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Behavioural multiplier core: fixed or random latency, done level
    // held until the next start, optional stale hold and hang modes.
    initial begin
        int               c_cnt;
        int               c_stale;
        bit               c_act;
        logic [63:0]      c_pend;
        mul_done    = 1'b0;
        mul_product = '0;
        c_act = 0; c_cnt = 0; c_stale = 0; c_pend = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mul_done = 1'b0;
                c_act = 0;
                c_stale = 0;
            end else if (mul_start) begin
                c_pend = smul(mul_multiplicand, mul_multiplier);
                c_cnt  = $urandom_range(lat_max, lat_min);
                c_act  = 1;
                if (keep_done && mul_done) begin
                    c_stale = 3;
                end else begin
                    c_stale = 0;
                    mul_done = 1'b0;
                end
            end else if (c_act) begin
                if (c_stale > 0) begin
                    c_stale--;
                    if (c_stale == 0) mul_done = 1'b0;
                end else if (c_cnt > 0) begin
                    c_cnt--;
                end else if (!core_hang) begin
                    mul_product = c_pend;
                    mul_done = 1'b1;
                    done_cyc = cyc;
                    c_act = 0;
                end
            end
        end
    end

    // Requesters: check each grant against the round-robin model,
    // record the expected result, then present the next operands.
    initial forever begin
        int    hs;
        exp_t  e;
        @(negedge clk);
        if (!rst && (req_valid & req_ready) != '0) begin
            chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
            hs = 0;
            for (int i = N - 1; i >= 0; i--)
                if (req_ready[i]) hs = i;
            chk("grant_id", 64'(hs), 64'(predict(req_valid, last_id)));
            e.id   = hs;
            e.err  = core_hang;
            e.prod = core_hang ? 64'd0
                   : smul(req_a[hs*W +: W], req_b[hs*W +: W]);
            exp_q.push_back(e);
            last_id = hs;
            @(posedge clk);
            #1;
            ops_left[hs]--;
            if (ops_left[hs] > 0) begin
                req_a[hs*W +: W] = rnd_op();
                req_b[hs*W +: W] = rnd_op();
            end else begin
                req_valid[hs] = 1'b0;
            end
        end
    end

    // Response scoreboard and done-to-response latency.
    initial begin
        bit   prev;
        exp_t e;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && !prev && !rsp_err)
                chk("rsp_latency", 64'(cyc), 64'(done_cyc + 1));
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_product", rsp_product, e.prod);
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end
            prev = rsp_valid;
        end
    end

    initial begin
        int           s;
        int           k;
        bit           ok;
        bit           quiet;
        logic [IDW-1:0] sid;
        logic [63:0]  sprod;
        logic         serr;
        logic [N-1:0] m;

        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) ops_left[i] = 0;

        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_product", rsp_product, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_mul_a", 64'(mul_multiplicand), 64'd0);
        chk("rst_mul_b", 64'(mul_multiplier), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single op from requester 0: 7 * -3.
        @(posedge clk);
        #1;
        ops_left[0] = 1;
        req_a[W-1:0] = 32'd7;
        req_b[W-1:0] = 32'hFFFF_FFFD;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("single_idle_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("single_grant", 64'(req_ready), 64'b0001);
        chk("single_expect_m21", exp_q[0].prod, 64'hFFFF_FFFF_FFFF_FFEB);
        drain("single_drain", 200);

        // All requesters continuously valid, two ops each.
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) load(i, 2);
        drain("all4_drain", 800);

        // Stale done level carried into the next ops.
        keep_done = 1;
        @(posedge clk);
        #1;
        load(1, 2);
        load(3, 1);
        drain("stale_drain", 600);
        keep_done = 0;

        // Core never completes: watchdog abort.
        core_hang = 1;
        @(posedge clk);
        #1;
        load(2, 1);
        k = 0;
        while (k < 50 && !mul_start) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_start_seen", 64'(mul_start), 64'd1);
        s = cyc;
        k = 0;
        while (k < 400 && !rsp_valid) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cycles", 64'(cyc - s), 64'(TMO + 1));
        chk("tmo_err", 64'(rsp_err), 64'd1);
        chk("tmo_product", rsp_product, 64'd0);
        drain("tmo_drain", 50);
        core_hang = 0;

        // Consumer stalls for 10 cycles while others are pending.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        load(1, 1);
        load(2, 1);
        k = 0;
        while (k < 200 && !rsp_valid) begin
            @(negedge clk);
            k++;
        end
        chk("stall_rsp_seen", 64'(rsp_valid), 64'd1);
        sid = rsp_id;
        sprod = rsp_product;
        serr = rsp_err;
        ok = 1;
        quiet = 1;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_id !== sid || rsp_product !== sprod ||
                rsp_err !== serr)
                ok = 0;
            if (mul_start || req_ready != '0)
                quiet = 0;
        end
        chk("stall_rsp_stable", 64'(ok), 64'd1);
        chk("stall_no_new_op", 64'(quiet), 64'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain("stall_drain", 400);

        // Reset in the middle of WAIT drops the op.
        lat_min = 60;
        lat_max = 60;
        @(posedge clk);
        #1;
        load(3, 1);
        k = 0;
        while (k < 50 && !mul_start) begin
            @(negedge clk);
            k++;
        end
        chk("rstw_start_seen", 64'(mul_start), 64'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstw_req_ready", 64'(req_ready), 64'd0);
        chk("rstw_mul_start", 64'(mul_start), 64'd0);
        chk("rstw_mul_a", 64'(mul_multiplicand), 64'd0);
        chk("rstw_mul_b", 64'(mul_multiplier), 64'd0);
        chk("rstw_rsp_product", rsp_product, 64'd0);
        chk("rstw_rsp_id", 64'(rsp_id), 64'd0);
        chk("rstw_rsp_err", 64'(rsp_err), 64'd0);
        req_valid = '0;
        for (int i = 0; i < N; i++) ops_left[i] = 0;
        exp_q.delete();
        last_id = N - 1;
        lat_min = 1;
        lat_max = 8;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet = 1;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid) quiet = 0;
        end
        chk("rstw_no_rsp", 64'(quiet), 64'd1);
        @(posedge clk);
        #1;
        load(2, 1);
        load(0, 1);
        drain("rstw_post_drain", 300);

        // Random mixes of requesters, latencies and done behaviour.
        for (int r = 0; r < 8; r++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            lat_min = $urandom_range(1, 4);
            lat_max = lat_min + $urandom_range(0, 10);
            keep_done = $urandom_range(0, 1);
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (m[i]) load(i, $urandom_range(1, 3));
            drain("rand_drain", 2000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
